sum4_bcc: RTL and testbench

SUM4_BCC -- requirements
Module: sum4_bcc

---
 rtl/sum4_bcc_pkg.sv | 14 +
 rtl/sum4_bcc_sum1bcc.sv | 18 +
 rtl/sum4_bcc.sv | 67 ++++++
 tb/tb_sum4_bcc.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sum4_bcc_pkg.sv
// Shared constants for the sum4_bcc registered ripple-carry adder.
//   SUM4_WIDTH : default operand width in bits
//   SUM4_RES_W : width of the full result {cout, S}
//   res_width(): result width for an arbitrary operand width
package sum4_bcc_pkg;

  localparam int SUM4_WIDTH = 4;
  localparam int SUM4_RES_W = SUM4_WIDTH + 1;

  function automatic int res_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sum4_bcc_sum1bcc.sv
// sum1bcc: purely combinational 1-bit full adder, one stage of the ripple chain.
// Ports:
//   a, b : operand bits
//   ci   : carry in from the previous stage
//   s    : sum bit
//   co   : carry out to the next stage
module sum1bcc (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sum4_bcc.sv
// sum4_bcc: unsigned adder built from a ripple chain of sum1bcc stages, with
// the result captured in an output register (one clock of latency).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears S, cout and out_valid
//   xi, yi    : unsigned addends
//   in_valid  : xi/yi are captured on this clock edge
//   S         : registered sum bits, (xi+yi) mod 2^WIDTH
//   cout      : registered carry out
//   out_valid : S/cout hold a result captured from a valid input
//
// Handshake: valid-only. Every edge with in_valid=1 captures a new result and
// raises out_valid for the following cycle; there is no ready, so the block
// accepts one operand pair per cycle without stalling. An edge with
// in_valid=0 keeps S/cout unchanged and drops out_valid.
module sum4_bcc
  import sum4_bcc_pkg::*;
#(
  parameter int WIDTH = SUM4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] yi,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             out_valid
);

  localparam int RES_W = res_width(WIDTH);

  // carry[i] is the carry into stage i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic [RES_W-1:0] res_comb;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    sum1bcc u_fa (
      .a  (xi[i]),
      .b  (yi[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  assign res_comb = {carry[WIDTH], sum_comb};

  // Result register. Operands are only looked at when in_valid is high, so
  // unknown values on xi/yi during idle cycles never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {cout, S} <= res_comb;
      end
    end
  end

endmodule

// File: tb/tb_sum4_bcc.sv
// Self-checking bench for sum4_bcc: directed reset/basic/carry cases, an
// exhaustive operand sweep, a mid-stream reset and a randomized run, all
// checked against plain integer addition.
module tb_sum4_bcc;

  logic       clk;
  logic       rst_n;
  logic [3:0] xi;
  logic [3:0] yi;
  logic       in_valid;
  logic [3:0] S;
  logic       cout;
  logic       out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected results of captured operand pairs, oldest first.
  logic [4:0] exp_q[$];
  // Value the output register should currently hold.
  logic [4:0] held;

  sum4_bcc #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xi        (xi),
    .yi        (yi),
    .in_valid  (in_valid),
    .S         (S),
    .cout      (cout),
    .out_valid (out_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge. Applies one operand pair across one rising
  // edge, then checks the outputs at the following negedge.
  task automatic drive_cycle(input string tag, input logic v, input logic [3:0] x,
                             input logic [3:0] y);
    in_valid = v;
    xi = x;
    yi = y;
    if (v) exp_q.push_back(5'(x) + 5'(y));
    @(posedge clk);
    @(negedge clk);
    if (v) held = exp_q.pop_front();
    check({tag, "_sum"}, 32'({cout, S}), 32'(held));
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_S"}, 32'(S), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b1;
    xi = 4'($urandom_range(0, 15));
    yi = 4'($urandom_range(0, 15));
    held = '0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_zero("rst_noclk");

    // Reset held through edges with valid operands present.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      xi = 4'($urandom_range(0, 15));
      yi = 4'($urandom_range(0, 15));
      @(negedge clk);
      check_zero("rst_clk");
    end
    rst_n = 1'b1;

    // Basic: 3+4, then hold with in_valid low.
    drive_cycle("basic", 1'b1, 4'd3, 4'd4);
    check("basic_S7", 32'(S), 32'd7);
    drive_cycle("hold", 1'b0, 4'd9, 4'd9);
    check("hold_S7", 32'(S), 32'd7);

    // Carry boundaries.
    drive_cycle("c15_15", 1'b1, 4'd15, 4'd15);
    check("c15_15_S", 32'(S), 32'd14);
    check("c15_15_cout", 32'(cout), 32'd1);
    drive_cycle("c9_7", 1'b1, 4'd9, 4'd7);
    check("c9_7_S", 32'(S), 32'd0);
    check("c9_7_cout", 32'(cout), 32'd1);
    drive_cycle("c15_1", 1'b1, 4'd15, 4'd1);
    drive_cycle("c0_0", 1'b1, 4'd0, 4'd0);
    check("c0_0_cout", 32'(cout), 32'd0);

    // Exhaustive sweep, one pair per cycle back to back.
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        drive_cycle("exh", 1'b1, 4'(x), 4'(y));
      end
    end

    // Mid-stream reset between two valid inputs.
    drive_cycle("pre_rst", 1'b1, 4'd5, 4'd6);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    exp_q.delete();
    held = '0;
    @(negedge clk);
    check_zero("mid_rst_clk");
    rst_n = 1'b1;
    drive_cycle("post_rst_idle", 1'b0, 4'd8, 4'd8);
    drive_cycle("post_rst", 1'b1, 4'd2, 4'd3);
    check("post_rst_S5", 32'(S), 32'd5);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      drive_cycle("rand", 1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
